// File: rtl/axis_frame_demux_pkg.sv
// rtl/axis_frame_demux_pkg.sv - shared types and constants for the frame demultiplexer
package axis_demux_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_SEL_W   = $clog2(DEF_NUM_CH);
  localparam int FRAME_CNT_W = 16;

  typedef logic [DEF_SEL_W-1:0] ch_idx_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic                  sof;
    logic                  eol;
  } beat_t;

  function automatic logic sel_in_range(input int unsigned sel, input int unsigned num_ch);
    return sel < num_ch;
  endfunction

endpackage

// File: rtl/axis_frame_demux_if.sv
// rtl/axis_frame_demux_if.sv - slave stream, fanned-out master streams and status of the demux
interface axis_frame_demux_if #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
);
  logic [DATA_W-1:0]        s_data_i;
  logic                     s_sof_i;
  logic                     s_eol_i;
  logic                     s_valid_i;
  logic                     s_ready_o;
  logic [NUM_CH*DATA_W-1:0] m_data_o;
  logic [NUM_CH-1:0]        m_sof_o;
  logic [NUM_CH-1:0]        m_eol_o;
  logic [NUM_CH-1:0]        m_valid_o;
  logic [NUM_CH-1:0]        m_ready_i;
  logic [SEL_W-1:0]         select_i;
  logic                     sel_err_o;
  logic                     busy_o;

  // slave: the demux itself; master: the environment around it
  modport slave (
    input  s_data_i, s_sof_i, s_eol_i, s_valid_i, m_ready_i, select_i,
    output s_ready_o, m_data_o, m_sof_o, m_eol_o, m_valid_o, sel_err_o, busy_o
  );

  modport master (
    output s_data_i, s_sof_i, s_eol_i, s_valid_i, m_ready_i, select_i,
    input  s_ready_o, m_data_o, m_sof_o, m_eol_o, m_valid_o, sel_err_o, busy_o
  );
endinterface

// File: rtl/axis_frame_demux_out_reg.sv
// rtl/axis_frame_demux_out_reg.sv - single-entry output register with pass-through ready
module axis_demux_out_reg #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              sof_i,
  input  logic              eol_i,
  input  logic [SEL_W-1:0]  ch_i,
  input  logic              bypass_i,
  input  logic [NUM_CH-1:0] m_ready_i,
  output logic              s_ready_o,
  output logic              valid_o,
  output logic [SEL_W-1:0]  ch_o,
  output logic [DATA_W-1:0] data_o,
  output logic              sof_o,
  output logic              eol_o
);
  logic drain;

  assign drain     = valid_o && m_ready_i[ch_o];
  // bypass lets discarded beats through while a stalled beat is still held
  assign s_ready_o = !valid_o || m_ready_i[ch_o] || bypass_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o <= 1'b0;
      ch_o    <= '0;
      data_o  <= '0;
      sof_o   <= 1'b0;
      eol_o   <= 1'b0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      ch_o    <= ch_i;
      data_o  <= data_i;
      sof_o   <= sof_i;
      eol_o   <= eol_i;
    end else if (drain) begin
      valid_o <= 1'b0;
    end
  end
endmodule

// File: rtl/axis_frame_demux.sv
// rtl/axis_frame_demux.sv - 1-to-N frame demux, destination latched on sof
// Optional per-channel frame counters: AXIS_FRAME_DEMUX_FRAME_CNT_EN
module axis_frame_demux
  import axis_demux_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic clk_i,
  input  logic rst_n_i,
  axis_frame_demux_if.slave bus
`ifdef AXIS_FRAME_DEMUX_FRAME_CNT_EN
  ,
  output logic [NUM_CH*FRAME_CNT_W-1:0] frame_cnt_o
`endif
);
  logic                     rdy_en_q;
  logic [SEL_W-1:0]         route_q;
  logic                     drop_q;
  logic                     sel_err_q;
  logic                     sof_oor;
  logic                     drop_now;
  logic                     accept;
  logic                     load;
  logic                     core_ready;
  logic [SEL_W-1:0]         dest;
  logic                     reg_valid;
  logic [SEL_W-1:0]         reg_ch;
  logic [DATA_W-1:0]        reg_data;
  logic                     reg_sof;
  logic                     reg_eol;
  logic [NUM_CH*DATA_W-1:0] m_data;
  logic [NUM_CH-1:0]        m_sof;
  logic [NUM_CH-1:0]        m_eol;
  logic [NUM_CH-1:0]        m_valid;

  assign sof_oor  = bus.s_sof_i && !sel_in_range(32'(bus.select_i), NUM_CH);
  // an in-range sof ends a dropped frame, so it must wait for the register like any beat
  assign drop_now = (drop_q && !bus.s_sof_i) || sof_oor;
  assign dest     = bus.s_sof_i ? bus.select_i : route_q;

  assign bus.s_ready_o = rdy_en_q && core_ready;
  assign accept        = bus.s_valid_i && bus.s_ready_o;
  assign load          = accept && !drop_now;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdy_en_q  <= 1'b0;
      route_q   <= '0;
      drop_q    <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (accept && bus.s_sof_i) begin
        route_q <= bus.select_i;
        drop_q  <= sof_oor;
        if (sof_oor) sel_err_q <= 1'b1;
      end
    end
  end

  axis_demux_out_reg #(
    .DATA_W(DATA_W),
    .NUM_CH(NUM_CH),
    .SEL_W (SEL_W)
  ) u_out_reg (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .load_i   (load),
    .data_i   (bus.s_data_i),
    .sof_i    (bus.s_sof_i),
    .eol_i    (bus.s_eol_i),
    .ch_i     (dest),
    .bypass_i (drop_now),
    .m_ready_i(bus.m_ready_i),
    .s_ready_o(core_ready),
    .valid_o  (reg_valid),
    .ch_o     (reg_ch),
    .data_o   (reg_data),
    .sof_o    (reg_sof),
    .eol_o    (reg_eol)
  );

  always_comb begin
    m_data  = '0;
    m_sof   = '0;
    m_eol   = '0;
    m_valid = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (reg_valid && reg_ch == SEL_W'(k)) begin
        m_valid[k]                  = 1'b1;
        m_sof[k]                    = reg_sof;
        m_eol[k]                    = reg_eol;
        m_data[k*DATA_W +: DATA_W]  = reg_data;
      end
    end
  end

  assign bus.m_data_o  = m_data;
  assign bus.m_sof_o   = m_sof;
  assign bus.m_eol_o   = m_eol;
  assign bus.m_valid_o = m_valid;
  assign bus.sel_err_o = sel_err_q;
  assign bus.busy_o    = reg_valid;

`ifdef AXIS_FRAME_DEMUX_FRAME_CNT_EN
  logic [NUM_CH*FRAME_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (m_valid[k] && bus.m_ready_i[k] && m_sof[k])
          cnt_q[k*FRAME_CNT_W +: FRAME_CNT_W] <= cnt_q[k*FRAME_CNT_W +: FRAME_CNT_W] + FRAME_CNT_W'(1);
      end
    end
  end

  assign frame_cnt_o = cnt_q;
`endif
endmodule
